// File: rtl/cla_pipe_pkg.sv
// cla_pipe_pkg: segment geometry helpers and defaults for cla_pipe_adder
package cla_pipe_pkg;
  localparam int CLA_PIPE_SEG_DEF = 16;
  function automatic int nseg(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction
  function automatic int seg_lo(input int k, input int seg);
    return k * seg;
  endfunction
  function automatic int seg_hi(input int k, input int seg, input int width);
    return (((k + 1) * seg < width) ? (k + 1) * seg : width) - 1;
  endfunction
endpackage

// File: rtl/cla_pipe_adder_seg.sv
// cla_seg: combinational W-bit carry-lookahead adder with 4-bit group generate/propagate
module cla_seg #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);
  localparam int NG = (W + 3) / 4;
  logic [4*NG-1:0] g, p;
  logic [NG-1:0] gg, gp;
  logic cg, cb;
  always_comb begin
    g = '0;
    p = '1;
    g[W-1:0] = a & b;
    p[W-1:0] = a ^ b;
    gg = '0;
    gp = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
  end
  always_comb begin
    sum = '0;
    cg = c_in;
    cb = c_in;
    for (int i = 0; i < W; i++) begin
      cb = (i % 4 == 0) ? cg : cb;
      sum[i] = p[i] ^ cb;
      cb = g[i] | (p[i] & cb);
      cg = (i % 4 == 3 || i == W - 1) ? (gg[i/4] | (gp[i/4] & cg)) : cg;
    end
    c_out = cg;
  end
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined segment-per-stage CLA add/sub with valid/ready; CLA_PIPE_OVF_EN adds ovf
module cla_pipe_adder
  import cla_pipe_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int SEG   = CLA_PIPE_SEG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NSEG = nseg(WIDTH, SEG);
  logic en;
  assign en = ~out_valid | out_ready;
  assign in_ready = en & ~rst;
  for (genvar k = 0; k < NSEG; k++) begin : g_st
    localparam int LO = seg_lo(k, SEG);
    localparam int HI = seg_hi(k, SEG, WIDTH);
    logic [WIDTH-1:LO] a_s, b_s;
    logic [HI-LO:0] seg_sum;
    logic [HI:0] sm_n, sm;
    logic c_s, v_s, seg_c, cy, vl;
    if (k == 0) begin : g_head
      assign a_s = a_in;
      assign b_s = b_in ^ {WIDTH{sub}};
      assign c_s = sub | c_in;
      assign v_s = in_valid;
      assign sm_n = seg_sum;
    end else begin : g_body
      assign a_s = g_st[k-1].g_skew.pa;
      assign b_s = g_st[k-1].g_skew.pb;
      assign c_s = g_st[k-1].cy;
      assign v_s = g_st[k-1].vl;
      assign sm_n = {seg_sum, g_st[k-1].sm};
    end
    cla_seg #(.W(HI - LO + 1)) u_seg (
      .a(a_s[HI:LO]),
      .b(b_s[HI:LO]),
      .c_in(c_s),
      .sum(seg_sum),
      .c_out(seg_c)
    );
    always_ff @(posedge clk)
      if (rst) begin
        sm <= '0;
        cy <= 1'b0;
        vl <= 1'b0;
      end else if (en) begin
        sm <= sm_n;
        cy <= seg_c;
        vl <= v_s;
      end
    if (k < NSEG - 1) begin : g_skew
      logic [WIDTH-1:HI+1] pa, pb;
      always_ff @(posedge clk)
        if (rst) begin
          pa <= '0;
          pb <= '0;
        end else if (en) begin
          pa <= a_s[WIDTH-1:HI+1];
          pb <= b_s[WIDTH-1:HI+1];
        end
    end
`ifdef CLA_PIPE_OVF_EN
    if (k == NSEG - 1) begin : g_ovf
      logic ov;
      always_ff @(posedge clk)
        if (rst) ov <= 1'b0;
        else if (en) ov <= seg_c ^ seg_sum[HI-LO] ^ a_s[WIDTH-1] ^ b_s[WIDTH-1];
    end
`endif
  end
  assign out_valid = g_st[NSEG-1].vl;
  assign sum = g_st[NSEG-1].sm;
  assign c_out = g_st[NSEG-1].cy;
`ifdef CLA_PIPE_OVF_EN
  assign ovf = g_st[NSEG-1].g_ovf.ov;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: table, directed and random checks of cla_pipe_adder against an arithmetic model
module tb_cla_pipe_adder;
  localparam int NS = 5;
  typedef struct {
    logic [64:0] s;
    logic c;
    logic o;
    int acc;
    bit lat;
  } exp_t;
  typedef struct {
    logic [64:0] a;
    logic [64:0] b;
    logic ci;
    logic sb;
    logic [64:0] s;
    logic c;
    logic o;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, c_in = 1'b0, sub = 1'b0, out_valid, out_ready = 1'b1, c_out;
  logic [64:0] a_in = '0, b_in = '0, sum;
  logic in_valid40 = 1'b0, in_ready40, out_valid40, c_out40;
  logic [39:0] a40 = '0, b40 = '0, sum40;
  logic ovf, ovf40;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit hold_v = 0;
  logic [64:0] hold_s;
  logic hold_c;
  exp_t exp_q[$];
  vec_t tbl[11];
  logic [64:0] ba[8], bb[8];
  always #5 clk = ~clk;
  cla_pipe_adder u_dut (
`ifdef CLA_PIPE_OVF_EN
    .ovf(ovf),
`endif
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out)
  );
  cla_pipe_adder #(.WIDTH(40), .SEG(16)) u_d40 (
`ifdef CLA_PIPE_OVF_EN
    .ovf(ovf40),
`endif
    .clk(clk), .rst(rst), .in_valid(in_valid40), .in_ready(in_ready40), .a_in(a40), .b_in(b40),
    .c_in(1'b0), .sub(1'b0), .out_valid(out_valid40), .out_ready(1'b1), .sum(sum40), .c_out(c_out40)
  );
`ifndef CLA_PIPE_OVF_EN
  assign ovf = 1'b0;
  assign ovf40 = 1'b0;
`endif
  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask
  function automatic exp_t model(input logic [64:0] a, input logic [64:0] b, input logic ci, input logic sb, input bit lat);
    exp_t e;
    logic [65:0] r;
    logic [64:0] be;
    if (sb) begin
      r[64:0] = a - b;
      r[65] = (a >= b);
    end else r = {1'b0, a} + {1'b0, b} + {65'd0, ci};
    be = sb ? ~b : b;
    e.s = r[64:0];
    e.c = r[65];
    e.o = (a[64] == be[64]) && (r[64] != a[64]);
    e.acc = 0;
    e.lat = lat;
    return e;
  endfunction
  function automatic logic [64:0] rnd65();
    logic [95:0] t;
    int k;
    t = {$urandom, $urandom, $urandom};
    k = $urandom_range(0, 7);
    return k == 0 ? 65'd0 : k == 1 ? {65{1'b1}} : k == 2 ? 65'h1_0000_0000_0000_0000 : t[64:0];
  endfunction
  task automatic step(input bit r, input bit iv, input logic [64:0] a, input logic [64:0] b, input logic ci,
                      input logic sb, input bit ordy, input int exp_rdy, input exp_t e, output bit acc);
    exp_t q;
    rst = r; in_valid = iv; a_in = a; b_in = b; c_in = ci; sub = sb; out_ready = ordy;
    @(negedge clk);
    acc = 0;
    if (exp_rdy >= 0) chk("in_ready", {64'd0, in_ready}, 65'(exp_rdy));
    if (!r) begin
      if (out_valid && !out_ready) begin
        if (hold_v) begin
          chk("stall_sum_held", sum, hold_s);
          chk("stall_cout_held", {64'd0, c_out}, {64'd0, hold_c});
        end
        hold_v = 1; hold_s = sum; hold_c = c_out;
      end else hold_v = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got sum %h with no beat outstanding", sum);
        end else begin
          q = exp_q.pop_front();
          chk("sum", sum, q.s);
          chk("c_out", {64'd0, c_out}, {64'd0, q.c});
`ifdef CLA_PIPE_OVF_EN
          chk("ovf", {64'd0, ovf}, {64'd0, q.o});
`endif
          if (q.lat) chk("latency", 65'(cyc - q.acc), 65'(NS));
        end
      end
      if (in_valid && in_ready) begin
        acc = 1;
        e.acc = cyc;
        exp_q.push_back(e);
      end
    end else hold_v = 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic idle(input bit r, input int exp_rdy);
    exp_t e;
    bit acc;
    e = model('0, '0, 1'b0, 1'b0, 0);
    step(r, 0, '0, '0, 1'b0, 1'b0, 1, exp_rdy, e, acc);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(0, -1);
    chk("drain_empty", 65'(exp_q.size()), 65'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    exp_t e;
    bit acc;
    int idx, cur, n;
    tbl[0]  = '{65'h1_FFFF_FFFF_FFFF_FFFF, 65'd1, 1'b0, 1'b0, 65'd0, 1'b1, 1'b0};
    tbl[1]  = '{65'h1_0000_0000_0000_0000, 65'hFFFF, 1'b1, 1'b0, 65'h1_0000_0000_0001_0000, 1'b0, 1'b0};
    tbl[2]  = '{65'd5, 65'd7, 1'b0, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[3]  = '{65'd7, 65'd5, 1'b0, 1'b1, 65'd2, 1'b1, 1'b0};
    tbl[4]  = '{65'd0, 65'd0, 1'b0, 1'b0, 65'd0, 1'b0, 1'b0};
    tbl[5]  = '{65'h1_FFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    tbl[6]  = '{65'h1234, 65'h1234, 1'b0, 1'b1, 65'd0, 1'b1, 1'b0};
    tbl[7]  = '{65'd3, 65'd1, 1'b1, 1'b1, 65'd2, 1'b1, 1'b0};
    tbl[8]  = '{65'h0_FFFF_FFFF_FFFF_FFFF, 65'd1, 1'b0, 1'b0, 65'h1_0000_0000_0000_0000, 1'b0, 1'b1};
    tbl[9]  = '{65'h1_0000_0000_0000_0000, 65'h1_0000_0000_0000_0000, 1'b0, 1'b0, 65'd0, 1'b1, 1'b1};
    tbl[10] = '{65'h1_0000_0000_0000_0000, 65'd1, 1'b0, 1'b1, 65'h0_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    idle(1, 0);
    idle(1, 0);
    chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
    chk("rst_sum", sum, 65'd0);
    chk("rst_c_out", {64'd0, c_out}, 65'd0);
    chk("rst_in_ready", {64'd0, in_ready}, 65'd0);
    chk("rst_ovf", {64'd0, ovf}, 65'd0);
    chk("rst_w40_valid", {64'd0, out_valid40}, 65'd0);
    idle(0, 1);
    for (int i = 0; i < 11; i++) begin
      e.s = tbl[i].s; e.c = tbl[i].c; e.o = tbl[i].o; e.acc = 0; e.lat = 1;
      step(0, 1, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb, 1, 1, e, acc);
      chk("tbl_accepted", {64'd0, acc}, 65'd1);
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      ba[i] = rnd65();
      bb[i] = rnd65();
    end
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      cur = idx < 8 ? idx : 0;
      e = model(ba[cur], bb[cur], 1'b0, cur % 2 == 1, 0);
      step(0, idx < 8, ba[cur], bb[cur], 1'b0, cur % 2 == 1, !(c >= 6 && c <= 9), (c >= 6 && c <= 9) ? 0 : 1, e, acc);
      if (acc) idx++;
    end
    chk("bp_all_accepted", 65'(idx), 65'd8);
    drain();
    for (int i = 0; i < 3; i++) begin
      e = model(ba[i], bb[i], 1'b1, 1'b0, 0);
      step(0, 1, ba[i], bb[i], 1'b1, 1'b0, 1, 1, e, acc);
    end
    idle(1, 0);
    exp_q.delete();
    chk("midrst_sum", sum, 65'd0);
    for (int i = 0; i < 6; i++) begin
      idle(0, 1);
      chk("midrst_quiet", {64'd0, out_valid}, 65'd0);
    end
    e = model(ba[5], bb[5], 1'b0, 1'b1, 1);
    step(0, 1, ba[5], bb[5], 1'b0, 1'b1, 1, 1, e, acc);
    drain();
    for (int i = 0; i < 300; i++) begin
      logic [64:0] ra, rb;
      logic rci, rsb;
      ra = rnd65(); rb = rnd65(); rci = 1'($urandom); rsb = 1'($urandom);
      e = model(ra, rb, rci, rsb, 0);
      step(0, $urandom_range(0, 3) != 0, ra, rb, rci, rsb, $urandom_range(0, 3) != 0, -1, e, acc);
    end
    drain();
    a40 = 40'hFF_FFFF_FFFF;
    b40 = 40'd1;
    in_valid40 = 1'b1;
    @(negedge clk);
    chk("w40_in_ready", {64'd0, in_ready40}, 65'd1);
    @(posedge clk);
    #1;
    in_valid40 = 1'b0;
    n = 0;
    while (!out_valid40 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w40_latency", 65'(n + 1), 65'd3);
    chk("w40_sum", {25'd0, sum40}, 65'd0);
    chk("w40_c_out", {64'd0, c_out40}, 65'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
